memory_bank_controller: RTL and testbench

//  Sequences one banked memory: narrow (WIDTH/BANKS) writes, full-WIDTH row reads.

---
 rtl/memory_bank_controller_if.sv | 43 ++++
 rtl/memory_bank_controller.sv | 119 +++++++++++
 tb/tb_memory_bank_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bank_controller_if.sv
// Bundle of the host-load, compute-read and memory-bank signals around memory_bank_controller.
// master = host/compute/bank side, slave = the controller.
interface memory_bank_controller_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int BANKS = 4
);
    localparam int LB = $clog2(BANKS);
    localparam int NW = WIDTH / BANKS;

    logic                  load_start;
    logic [DEPTH+LB-1:0]   load_base;
    logic [DEPTH+LB:0]     load_len;
    logic                  load_valid;
    logic [NW-1:0]         load_data;
    logic                  load_ready;
    logic                  load_busy;
    logic                  load_done;
    logic                  rd_req;
    logic [DEPTH-1:0]      rd_addr;
    logic                  rd_grant;
    logic                  rd_valid;
    logic [WIDTH-1:0]      rd_data;
    logic                  mem_write_enable;
    logic [DEPTH+LB-1:0]   mem_write_addr;
    logic [NW-1:0]         mem_data_in;
    logic [DEPTH-1:0]      mem_read_addr;
    logic [WIDTH-1:0]      mem_data_out;

    modport master (
        output load_start, load_base, load_len, load_valid, load_data,
               rd_req, rd_addr, mem_data_out,
        input  load_ready, load_busy, load_done, rd_grant, rd_valid, rd_data,
               mem_write_enable, mem_write_addr, mem_data_in, mem_read_addr
    );

    modport slave (
        input  load_start, load_base, load_len, load_valid, load_data,
               rd_req, rd_addr, mem_data_out,
        output load_ready, load_busy, load_done, rd_grant, rd_valid, rd_data,
               mem_write_enable, mem_write_addr, mem_data_in, mem_read_addr
    );
endinterface

// File: rtl/memory_bank_controller.sv
// Banked-memory sequencer: streams narrow host words into a row-aligned region, gates full-row reads.
// Optional macro READ_DURING_LOAD_EN: rows completed by the active load become readable mid-load.
//
// state  | meaning
// S_IDLE | no load active; reads always granted
// S_LOAD | accepting narrow words; reads gated
module memory_bank_controller #(
    parameter int DEPTH        = 4,
    parameter int WIDTH        = 64,
    parameter int BANKS        = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    memory_bank_controller_if.slave bus
);
    localparam int LB = $clog2(BANKS);
    localparam int AW = DEPTH + LB;
    localparam int LW = AW + 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    state_t                  r_state, w_state_nxt;
    logic [AW-1:0]           r_ptr;
    logic [LW-1:0]           r_remaining;
    logic                    r_done;
    logic [READ_LATENCY-1:0] r_vpipe;

    logic w_accept, w_start, w_done_nxt, w_last, w_allow, w_grant;
    logic w_unused_base;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done_nxt  = 1'b0;
        w_last      = (r_remaining == LW'(1));
        w_accept    = (r_state == S_LOAD) && bus.load_valid;
        case (r_state)
            S_IDLE: begin
                if (bus.load_start) begin
                    if (bus.load_len != '0) begin
                        w_start     = 1'b1;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_vpipe     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_vpipe[0] <= w_grant;
            for (int i = 1; i < READ_LATENCY; i++) r_vpipe[i] <= r_vpipe[i-1];
            if (w_start) begin
                r_ptr       <= {bus.load_base[AW-1:LB], {LB{1'b0}}};
                r_remaining <= bus.load_len;
            end else if (w_accept) begin
                r_ptr       <= r_ptr + AW'(1);
                r_remaining <= r_remaining - LW'(1);
            end
        end
    end

`ifdef READ_DURING_LOAD_EN
    logic [DEPTH-1:0] r_base_row;
    logic [DEPTH-1:0] w_row_off;
    logic [DEPTH:0]   r_rows_done;

    // A row counts as done when its last bank lane is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base_row  <= '0;
            r_rows_done <= '0;
        end else if (w_start) begin
            r_base_row  <= bus.load_base[AW-1:LB];
            r_rows_done <= '0;
        end else if (w_accept && (r_ptr[LB-1:0] == LB'(BANKS-1))) begin
            r_rows_done <= r_rows_done + (DEPTH+1)'(1);
        end
    end

    // Offset from the load's base row, modulo the row count, so wrapped loads gate correctly.
    assign w_row_off = bus.rd_addr - r_base_row;
    assign w_allow   = (r_state == S_IDLE) || ({1'b0, w_row_off} < r_rows_done);
`else
    assign w_allow   = (r_state == S_IDLE);
`endif

    assign w_grant       = bus.rd_req && w_allow;
    assign w_unused_base = &{1'b0, bus.load_base[LB-1:0]};

    assign bus.load_ready       = (r_state == S_LOAD);
    assign bus.load_busy        = (r_state == S_LOAD);
    assign bus.load_done        = r_done;
    assign bus.rd_grant         = w_grant;
    assign bus.rd_valid         = r_vpipe[READ_LATENCY-1];
    assign bus.rd_data          = bus.mem_data_out;
    assign bus.mem_write_enable = w_accept;
    assign bus.mem_write_addr   = r_ptr;
    assign bus.mem_data_in      = bus.load_data;
    assign bus.mem_read_addr    = bus.rd_addr;
endmodule

// File: tb/tb_memory_bank_controller.sv
// Directed bench for memory_bank_controller with a behavioural one-cycle-latency bank model.
module tb_memory_bank_controller;
    localparam int DEPTH = 4;
    localparam int WIDTH = 64;
    localparam int BANKS = 4;
    localparam int NW    = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    memory_bank_controller_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .BANKS(BANKS)) bus();

    memory_bank_controller #(
        .DEPTH(DEPTH), .WIDTH(WIDTH), .BANKS(BANKS), .READ_LATENCY(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [NW-1:0] mem [64];

    always @(posedge clk) begin
        if (bus.mem_write_enable) mem[bus.mem_write_addr] <= bus.mem_data_in;
        bus.mem_data_out <= {mem[{bus.mem_read_addr, 2'd3}], mem[{bus.mem_read_addr, 2'd2}],
                             mem[{bus.mem_read_addr, 2'd1}], mem[{bus.mem_read_addr, 2'd0}]};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_load(input logic [5:0] base, input int len, input logic [15:0] d0,
                           input bit gap, input bit rd_chk, input bit hold_start);
        logic [5:0] ptr_exp;
        logic       grant_exp;
        bus.load_start = 1'b1;
        bus.load_base  = base;
        bus.load_len   = 7'(len);
        @(negedge clk);
        check("idle_ready", bus.load_ready, 1'b0);
        @(posedge clk); #1;
        bus.load_start = hold_start;
        if (hold_start) bus.load_base = 6'h30;
        ptr_exp = {base[5:2], 2'b00};
        if (rd_chk) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = base[5:2];
        end
        for (int i = 0; i < len; i++) begin
            if (gap) begin
                bus.load_valid = 1'b0;
                @(negedge clk);
                check("gap_we", bus.mem_write_enable, 1'b0);
                check("gap_ready", bus.load_ready, 1'b1);
                check("gap_addr", bus.mem_write_addr, ptr_exp);
                @(posedge clk); #1;
            end
            bus.load_valid = 1'b1;
            bus.load_data  = 16'(d0 + 16'(i));
            @(negedge clk);
            check("wr_we", bus.mem_write_enable, 1'b1);
            check("wr_addr", bus.mem_write_addr, ptr_exp);
            check("wr_data", bus.mem_data_in, 16'(d0 + 16'(i)));
            check("wr_busy", bus.load_busy, 1'b1);
            if (rd_chk) begin
`ifdef READ_DURING_LOAD_EN
                grant_exp = (i >= 4);
`else
                grant_exp = 1'b0;
`endif
                check("load_grant", bus.rd_grant, grant_exp);
            end
            @(posedge clk); #1;
            ptr_exp = ptr_exp + 6'd1;
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
        bus.rd_req     = 1'b0;
        @(negedge clk);
        check("done_pulse", bus.load_done, 1'b1);
        check("done_busy", bus.load_busy, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("done_clear", bus.load_done, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [3:0] row, input logic [63:0] exp);
        bus.rd_req  = 1'b1;
        bus.rd_addr = row;
        @(negedge clk);
        check("rd_grant", bus.rd_grant, 1'b1);
        check("rd_maddr", bus.mem_read_addr, row);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("rd_valid", bus.rd_valid, 1'b1);
        check("rd_data", bus.rd_data, exp);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_valid_off", bus.rd_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_base  = '0;
        bus.load_len   = '0;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", bus.load_ready, 1'b0);
        check("rst_busy", bus.load_busy, 1'b0);
        check("rst_done", bus.load_done, 1'b0);
        check("rst_valid", bus.rd_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned load with a read held on its first row.
        do_load(6'h08, 8, 16'h00A0, 1'b0, 1'b1, 1'b0);
        do_read(4'd2, 64'h00A3_00A2_00A1_00A0);

        // Back-to-back reads of rows 2 and 3.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd2;
        @(posedge clk); #1;
        bus.rd_addr = 4'd3;
        @(negedge clk);
        check("b2b_valid0", bus.rd_valid, 1'b1);
        check("b2b_data0", bus.rd_data, 64'h00A3_00A2_00A1_00A0);
        @(posedge clk); #1;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("b2b_valid1", bus.rd_valid, 1'b1);
        check("b2b_data1", bus.rd_data, 64'h00A7_00A6_00A5_00A4);
        @(posedge clk); #1;

        // Gapped load_valid, load_start held high mid-load must be ignored.
        do_load(6'h10, 4, 16'h00B0, 1'b1, 1'b0, 1'b1);
        do_read(4'd4, 64'h00B3_00B2_00B1_00B0);

        // Wrap from row 15 into row 0.
        do_load(6'h3C, 8, 16'h00C0, 1'b0, 1'b0, 1'b0);
        do_read(4'd15, 64'h00C3_00C2_00C1_00C0);
        do_read(4'd0, 64'h00C7_00C6_00C5_00C4);

        // Unaligned base is forced onto the row boundary (0x15 -> 0x14).
        do_load(6'h15, 2, 16'h00D0, 1'b0, 1'b0, 1'b0);
        do_read(4'd5, 64'h0000_0000_00D1_00D0);

        // Zero-length load.
        bus.load_start = 1'b1;
        bus.load_len   = '0;
        @(negedge clk);
        check("len0_we", bus.mem_write_enable, 1'b0);
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        @(negedge clk);
        check("len0_done", bus.load_done, 1'b1);
        check("len0_busy", bus.load_busy, 1'b0);
        check("len0_we2", bus.mem_write_enable, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("len0_done_clr", bus.load_done, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a load.
        bus.load_start = 1'b1;
        bus.load_base  = 6'h20;
        bus.load_len   = 7'd8;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h00E0;
        @(posedge clk); #1;
        bus.load_data  = 16'h00E1;
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        check("mid_busy_pre", bus.load_busy, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_busy", bus.load_busy, 1'b0);
        check("mid_ready", bus.load_ready, 1'b0);
        check("mid_done", bus.load_done, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_done2", bus.load_done, 1'b0);
        @(posedge clk); #1;
        do_read(4'd8, 64'h0000_0000_00E1_00E0);

        // Reset on the grant edge drops the in-flight valid.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd2;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        bus.rd_req = 1'b0;
        @(negedge clk);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
